// File: rtl/seg_mux_ctrl.sv
// rtl/seg_mux_ctrl.sv - two-digit seven-segment time-multiplexing controller
// Blank/show schedule sharing one hex decoder between two common-anode digits.
module seg_mux_ctrl #(
    parameter int SHOW_CYCLES  = 24000,
    parameter int BLANK_CYCLES = 480
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [3:0] s0,
    input  logic [3:0] s1,
    output logic [3:0] hex,
    output logic [1:0] an_n,
    output logic       digit,
    output logic       frame_tick
);

    localparam int MAXD = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CW   = (MAXD > 1) ? $clog2(MAXD) : 1;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_BLANK0,
        ST_SHOW0,
        ST_BLANK1,
        ST_SHOW1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   last_cnt;
    logic [3:0]      hex_q, hex_d;
    logic [1:0]      an_n_q, an_n_d;
    logic            digit_q, digit_d;
    logic            tick_q, tick_d;

    always_comb begin
        last_cnt = '0;
        case (state_q)
            ST_BLANK0, ST_BLANK1: last_cnt = CW'(BLANK_CYCLES - 1);
            ST_SHOW0, ST_SHOW1:   last_cnt = CW'(SHOW_CYCLES - 1);
            default:              last_cnt = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!en) begin
            state_d = ST_OFF;
            cnt_d   = '0;
        end else if (state_q == ST_OFF) begin
            state_d = ST_BLANK0;
            cnt_d   = '0;
        end else if (cnt_q == last_cnt) begin
            cnt_d = '0;
            case (state_q)
                ST_BLANK0: state_d = ST_SHOW0;
                ST_SHOW0:  state_d = ST_BLANK1;
                ST_BLANK1: state_d = ST_SHOW1;
                default:   state_d = ST_BLANK0;
            endcase
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        an_n_d  = 2'b11;
        digit_d = 1'b0;
        hex_d   = hex_q;
        tick_d  = 1'b0;
        case (state_d)
            ST_SHOW0: an_n_d = 2'b10;
            ST_SHOW1: an_n_d = 2'b01;
            default:  an_n_d = 2'b11;
        endcase
        digit_d = (state_d == ST_BLANK1) || (state_d == ST_SHOW1);
        if ((state_q == ST_BLANK0) || (state_d == ST_BLANK0)) begin
            hex_d = s0;
        end else if ((state_q == ST_BLANK1) || (state_d == ST_BLANK1)) begin
            hex_d = s1;
        end
        tick_d = (state_q == ST_SHOW1) && (state_d == ST_BLANK0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_BLANK0;
            cnt_q   <= '0;
            hex_q   <= 4'h0;
            an_n_q  <= 2'b11;
            digit_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hex_q   <= hex_d;
            an_n_q  <= an_n_d;
            digit_q <= digit_d;
            tick_q  <= tick_d;
        end
    end

    assign hex        = hex_q;
    assign an_n       = an_n_q;
    assign digit      = digit_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_mux_ctrl.sv
// tb/tb_seg_mux_ctrl.sv - self-checking bench for seg_mux_ctrl
// Two instances (S=4/B=2 and S=1/B=1) driven with the same inputs.
module tb_seg_mux_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b1;
    logic [3:0] s0 = 4'h0;
    logic [3:0] s1 = 4'h0;

    logic [3:0] hex_a, hex_b;
    logic [1:0] an_a, an_b;
    logic       dig_a, dig_b, tick_a, tick_b;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seg_mux_ctrl #(.SHOW_CYCLES(4), .BLANK_CYCLES(2)) u_a (
        .clk(clk), .reset_n(reset_n), .en(en), .s0(s0), .s1(s1),
        .hex(hex_a), .an_n(an_a), .digit(dig_a), .frame_tick(tick_a)
    );

    seg_mux_ctrl #(.SHOW_CYCLES(1), .BLANK_CYCLES(1)) u_b (
        .clk(clk), .reset_n(reset_n), .en(en), .s0(s0), .s1(s1),
        .hex(hex_b), .an_n(an_b), .digit(dig_b), .frame_tick(tick_b)
    );

    // Reference model: position within the frame, segment derived arithmetically.
    typedef struct {
        bit         off;
        int         pos;
        logic [3:0] hex;
        logic [1:0] an_n;
        logic       digit;
        logic       tick;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.off = 0; m.pos = 0; m.hex = 4'h0; m.an_n = 2'b11; m.digit = 1'b0; m.tick = 1'b0;
        return m;
    endfunction

    // 0=BLANK0 1=SHOW0 2=BLANK1 3=SHOW1
    function automatic int seg_of(int pos, int s, int b);
        if (pos < b) return 0;
        if (pos < b + s) return 1;
        if (pos < 2 * b + s) return 2;
        return 3;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, logic e, logic [3:0] v0, logic [3:0] v1, int s, int b);
        mdl_t n;
        int cur, nxt;
        n = m;
        cur = m.off ? -1 : seg_of(m.pos, s, b);
        if (!e) begin
            n.off = 1; n.pos = 0;
        end else if (m.off) begin
            n.off = 0; n.pos = 0;
        end else begin
            n.pos = (m.pos + 1) % (2 * (s + b));
        end
        nxt = n.off ? -1 : seg_of(n.pos, s, b);
        if (cur == 0 || nxt == 0) n.hex = v0;
        else if (cur == 2 || nxt == 2) n.hex = v1;
        n.an_n  = (nxt == 1) ? 2'b10 : (nxt == 3) ? 2'b01 : 2'b11;
        n.digit = (nxt >= 2);
        n.tick  = (cur == 3) && (nxt == 0);
        return n;
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_models(input string tag);
        check({tag, " a.an_n"},  {6'd0, an_a},   {6'd0, ma.an_n});
        check({tag, " a.hex"},   {4'd0, hex_a},  {4'd0, ma.hex});
        check({tag, " a.digit"}, {7'd0, dig_a},  {7'd0, ma.digit});
        check({tag, " a.tick"},  {7'd0, tick_a}, {7'd0, ma.tick});
        check({tag, " b.an_n"},  {6'd0, an_b},   {6'd0, mb.an_n});
        check({tag, " b.hex"},   {4'd0, hex_b},  {4'd0, mb.hex});
        check({tag, " b.digit"}, {7'd0, dig_b},  {7'd0, mb.digit});
        check({tag, " b.tick"},  {7'd0, tick_b}, {7'd0, mb.tick});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ma = mdl_step(ma, en, s0, s1, 4, 2);
        mb = mdl_step(mb, en, s0, s1, 1, 1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        ma = mdl_reset();
        mb = mdl_reset();
    endtask

    // Safety: never both anodes on, never a two-cycle frame_tick.
    logic prev_tick_a = 1'b0, prev_tick_b = 1'b0;
    always @(negedge clk) begin
        check("safe a.an_n!=00", {7'd0, an_a == 2'b00}, 8'd0);
        check("safe b.an_n!=00", {7'd0, an_b == 2'b00}, 8'd0);
        check("safe a.tick x2", {7'd0, tick_a & prev_tick_a}, 8'd0);
        check("safe b.tick x2", {7'd0, tick_b & prev_tick_b}, 8'd0);
        prev_tick_a = tick_a;
        prev_tick_b = tick_b;
    end

    typedef struct {
        logic [1:0] an;
        logic [3:0] hex;
        logic       tick;
        logic       dig;
    } vec_t;

    vec_t vt[12];

    initial begin
        int   ticks;
        logic [3:0] frz;

        // Expected schedule for S=4, B=2, s0=3, s1=A, indexed by edge-1 within a 12-edge frame.
        vt[0]  = '{2'b11, 4'h3, 1'b0, 1'b0};
        vt[1]  = '{2'b10, 4'h3, 1'b0, 1'b0};
        vt[2]  = '{2'b10, 4'h3, 1'b0, 1'b0};
        vt[3]  = '{2'b10, 4'h3, 1'b0, 1'b0};
        vt[4]  = '{2'b10, 4'h3, 1'b0, 1'b0};
        vt[5]  = '{2'b11, 4'hA, 1'b0, 1'b1};
        vt[6]  = '{2'b11, 4'hA, 1'b0, 1'b1};
        vt[7]  = '{2'b01, 4'hA, 1'b0, 1'b1};
        vt[8]  = '{2'b01, 4'hA, 1'b0, 1'b1};
        vt[9]  = '{2'b01, 4'hA, 1'b0, 1'b1};
        vt[10] = '{2'b01, 4'hA, 1'b0, 1'b1};
        vt[11] = '{2'b11, 4'h3, 1'b1, 1'b0};

        ma = mdl_reset();
        mb = mdl_reset();

        // Reset held: outputs stay at reset values regardless of inputs.
        reset_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            en = 1'($urandom_range(0, 1));
            s0 = 4'($urandom);
            s1 = 4'($urandom);
            @(posedge clk);
            #1;
            check("rst a.an_n", {6'd0, an_a}, 8'h03);
            check("rst a.hex", {4'd0, hex_a}, 8'h00);
            check("rst a.digit", {7'd0, dig_a}, 8'h00);
            check("rst a.tick", {7'd0, tick_a}, 8'h00);
            check("rst b.an_n", {6'd0, an_b}, 8'h03);
        end

        // Schedule: two full frames from table, minimum-parameter instance against model.
        en = 1'b1; s0 = 4'h3; s1 = 4'hA;
        do_reset();
        ticks = 0;
        for (int e = 1; e <= 24; e++) begin
            step();
            check($sformatf("sched e%0d an_n", e), {6'd0, an_a}, {6'd0, vt[(e - 1) % 12].an});
            check($sformatf("sched e%0d hex", e), {4'd0, hex_a}, {4'd0, vt[(e - 1) % 12].hex});
            check($sformatf("sched e%0d tick", e), {7'd0, tick_a}, {7'd0, vt[(e - 1) % 12].tick});
            check($sformatf("sched e%0d digit", e), {7'd0, dig_a}, {7'd0, vt[(e - 1) % 12].dig});
            cmp_models("sched");
            if (tick_b) ticks++;
        end
        check("min-param ticks in 24", 8'(ticks), 8'd6);

        // Input freeze: s0 changes during SHOW0, shown value updates only in next BLANK0.
        do_reset();
        step(); step();
        s0 = 4'h7;
        for (int e = 3; e <= 13; e++) begin
            step();
            if (e <= 5) check($sformatf("freeze e%0d hex", e), {4'd0, hex_a}, 8'h03);
            if (e == 13) check("freeze e13 hex", {4'd0, hex_a}, 8'h07);
            cmp_models("freeze");
        end
        s0 = 4'h3;

        // Enable drop during SHOW1 at edge 9, held low 20 cycles, then raised.
        do_reset();
        for (int e = 1; e <= 8; e++) step();
        en = 1'b0;
        step();
        check("en0 e9 an_n", {6'd0, an_a}, 8'h03);
        check("en0 e9 hex", {4'd0, hex_a}, 8'h0A);
        frz = hex_a;
        for (int i = 0; i < 20; i++) begin
            s0 = 4'($urandom); s1 = 4'($urandom);
            step();
            check("en0 hold an_n", {6'd0, an_a}, 8'h03);
            check("en0 hold hex", {4'd0, hex_a}, {4'd0, frz});
            cmp_models("en0");
        end
        en = 1'b1; s0 = 4'h5;
        step();
        check("en1 an_n", {6'd0, an_a}, 8'h03);
        check("en1 tick", {7'd0, tick_a}, 8'h00);
        check("en1 digit", {7'd0, dig_a}, 8'h00);
        step();
        check("en1+1 an_n", {6'd0, an_a}, 8'h03);
        step();
        check("en1+2 an_n", {6'd0, an_a}, 8'h02);
        check("en1+2 hex", {4'd0, hex_a}, 8'h05);

        // Asynchronous reset mid-SHOW1: outputs clear before the next edge.
        s0 = 4'h3; s1 = 4'hA;
        do_reset();
        for (int e = 1; e <= 9; e++) step();
        check("pre-arst an_n", {6'd0, an_a}, 8'h01);
        #2 reset_n = 1'b0;
        #1;
        check("arst an_n", {6'd0, an_a}, 8'h03);
        check("arst hex", {4'd0, hex_a}, 8'h00);
        check("arst digit", {7'd0, dig_a}, 8'h00);
        check("arst tick", {7'd0, tick_a}, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        ma = mdl_reset();
        mb = mdl_reset();

        // Randomised run against the reference model.
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 3) == 0) s0 = 4'($urandom);
            if ($urandom_range(0, 3) == 0) s1 = 4'($urandom);
            step();
            cmp_models("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
